key_schedule_reverse: RTL and testbench
=======================================

Name: key_schedule_reverse

Overview:
- Inverse-direction AES-128 key expander for the decryption datapath.
- Takes the final (round-10) round key and walks the schedule backwards, emitting round keys 10, 9, …, 0 one at a time over a valid/ready stream.
- Recovers each previous round key from the current one using the same g-function as the forward schedule: RotWord, forward SubWord, XOR of the Rcon into the MSB byte.
- Sits between the key-expansion store and the inverse-cipher round engine.

Parameters:
- NR, 10: number of rounds. Only 10 (AES-128) is supported.
- RCON_LAST, 8'h36: Rcon for round NR; the starting value of the Rcon register.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request to begin a reverse walk; sampled only when in_ready=1.
- key_in  input  128  round-NR key, words w0..w3 with w0 = key_in[127:96].
- in_ready  output  1  high in IDLE only.
- out_valid  output  1  out_key/out_round hold a valid round key.
- out_ready  input  1  downstream accepts the current key.
- out_key  output  128  current round key, same word order as key_in.
- out_round  output  4  round index of out_key, 10 down to 0.
- done  output  1  one-cycle pulse when round 0 is accepted.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE, key_reg=0, round=0, rcon=RCON_LAST.
  - in_ready=1 once in IDLE; out_valid=0, out_key=0, out_round=0, done=0.
- States: IDLE, EMIT.
- IDLE:
  - in_ready=1.
  - start=1 at edge T: key_reg<=key_in, round<=NR, rcon<=RCON_LAST, go to EMIT.
  - out_valid=1 from cycle T+1. Latency is 1 cycle.
- EMIT:
  - out_valid=1, out_key=key_reg, out_round=round, in_ready=0.
  - Outputs are held stable while out_ready=0; no change of any register.
  - Handshake (out_valid & out_ready) with round>0:
    - key_reg<=prev(key_reg), round<=round-1, rcon<=inv_xtime(rcon).
    - Stay in EMIT; the next key is valid the following cycle.
  - Handshake with round==0: done=1 for that cycle (combinational from handshake, or registered so it pulses the cycle after); go to IDLE; out_valid=0 next cycle.
- prev(w0,w1,w2,w3):
  - p3=w3^w2, p2=w2^w1, p1=w1^w0.
  - p0 = w0 ^ g(p3), where g(x) = SubWord(RotWord(x)) ^ {rcon,24'h0}.
  - RotWord({a,b,c,d}) = {b,c,d,a}.
  - SubWord applies the forward AES S-box per byte, combinational, 4 lookups.
- inv_xtime(r) = r[0] ? ((r ^ 9'h11B) >> 1) : (r >> 1), 8-bit result.
  - Sequence: 36, 1B, 80, 40, 20, 10, 08, 04, 02, 01.
  - The value after 01 is never used.
- Throughput: 11 keys in a minimum of 11 cycles with out_ready held at 1; one key per handshake.
- start while in EMIT is ignored (in_ready=0). No queuing.
- start in the same cycle as the final handshake is ignored; it is accepted the next cycle in IDLE.
- reset asserted mid-walk: immediate abort to reset values; no done pulse.
- key_in is sampled only at acceptance; later changes have no effect.
- out_round never underflows; round 0 is always the last key emitted.

Test Plan:
1. FIPS-197 A.1 walk:
   - Stimulus: key_in=d014f9a8c9ee2589e13f0cc8b6630ca6, start=1, out_ready=1.
   - out_round 10 → key = input.
   - out_round 9 → ac7766f319fadc2128d12941575c006e.
   - out_round 0 → 2b7e151628aed2a6abf7158809cf4f3c.
   - done pulses once; exactly 11 handshakes.
2. Backpressure:
   - Stimulus: same key; out_ready low for 3 cycles at round 7, and low on alternating cycles elsewhere.
   - Outputs held constant during stalls; key sequence identical to scenario 1; no skipped or duplicated rounds.
3. Busy start:
   - Stimulus: pulse start with a different key_in at round 5.
   - Ignored; the walk completes with the original keys; in_ready=0 throughout EMIT.
4. Back-to-back walks:
   - Stimulus: start held high continuously.
   - After done, IDLE for 1 cycle, then a new walk; first key of walk 2 = key_in sampled at that IDLE cycle.
5. Reset mid-operation:
   - Stimulus: assert reset at round 4.
   - Same cycle: out_valid=0, done=0, in_ready=1 after release.
   - A new start yields the correct round-10 key.
6. Rcon chain (white-box):
   - Stimulus: any key; record rcon at each handshake.
   - Required sequence: 36, 1B, 80, 40, 20, 10, 08, 04, 02, 01.
   - Cross-check against a random-key forward expansion in the bench model for 100 keys.

Source files
------------

// File: rtl/key_schedule_reverse.sv
// Reverse AES-128 key schedule: starts from the round-10 key and streams
// round keys 10 down to 0 over a valid/ready interface.
module key_schedule_reverse #(
    parameter int unsigned NR        = 10,
    parameter logic [7:0]  RCON_LAST = 8'h36
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_key,
    output logic [3:0]   out_round,
    output logic         done
);

    localparam int unsigned KEY_W  = 128;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned RND_W  = 4;
    localparam logic [RND_W-1:0] ROUND_LAST = RND_W'(NR);

    // Forward AES S-box, entry 0x00 in the top byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic {IDLE, EMIT} state_t;

    state_t             state_q, state_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [RND_W-1:0]   round_q, round_d;
    logic [7:0]         rcon_q, rcon_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               done_q, done_d;

    logic [KEY_W-1:0]   prev_key;
    logic [7:0]         rcon_prev;
    logic [WORD_W-1:0]  w0, w1, w2, w3, p3;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b000} +: 8];
    endfunction

    // g(x) = SubWord(RotWord(x)) ^ {rc, 24'h0}
    function automatic logic [WORD_W-1:0] g_fn(input logic [WORD_W-1:0] x,
                                               input logic [7:0]        rc);
        return {sbox(x[23:16]) ^ rc, sbox(x[15:8]), sbox(x[7:0]), sbox(x[31:24])};
    endfunction

    // Undo one forward expansion step; rcon steps back via division by x in GF(2^8).
    always_comb begin
        w0        = key_q[127:96];
        w1        = key_q[95:64];
        w2        = key_q[63:32];
        w3        = key_q[31:0];
        p3        = w3 ^ w2;
        prev_key  = {w0 ^ g_fn(p3, rcon_q), w1 ^ w0, w2 ^ w1, p3};
        rcon_prev = rcon_q[0] ? ((rcon_q >> 1) ^ 8'h8D) : (rcon_q >> 1);
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        rcon_d  = rcon_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d   = key_in;
                    round_d = ROUND_LAST;
                    rcon_d  = RCON_LAST;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (round_q != '0) begin
                        key_d   = prev_key;
                        round_d = round_q - RND_W'(1);
                        rcon_d  = rcon_prev;
                    end else begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == EMIT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            key_q       <= '0;
            round_q     <= '0;
            rcon_q      <= RCON_LAST;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            round_q     <= round_d;
            rcon_q      <= rcon_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_key   = key_q;
    assign out_round = round_q;
    assign done      = done_q;

endmodule

// File: tb/tb_key_schedule_reverse.sv
// Directed bench for key_schedule_reverse: FIPS-197 walk, backpressure,
// busy start, back-to-back, mid-walk reset, Rcon chain and random keys.
module tb_key_schedule_reverse;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] key_in;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_key;
    logic [3:0]   out_round;
    logic         done;

    int errors = 0;
    int checks = 0;
    int hs_count = 0;
    int done_count = 0;
    logic [7:0] rcon_log[$];

    logic [127:0] exp_keys[0:10];
    logic [7:0]   exp_rcon[0:9];

    localparam logic [2047:0] TB_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    key_schedule_reverse dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .key_in    (key_in),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_key   (out_key),
        .out_round (out_round),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Handshake / done counters and Rcon capture for non-final handshakes.
    always @(posedge clk) begin
        if (out_valid && out_ready) begin
            hs_count <= hs_count + 1;
            if (out_round != 4'd0) rcon_log.push_back(dut.rcon_q);
        end
        if (done) done_count <= done_count + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] tb_sbox(input logic [7:0] x);
        return TB_SBOX[2047 - 8 * int'(x) -: 8];
    endfunction

    // Forward AES-128 expansion: fills exp_keys[0..10] and the reversed Rcon order.
    task automatic fwd_expand(input logic [127:0] k);
        logic [31:0] w0, w1, w2, w3, t;
        logic [7:0]  rc;
        {w0, w1, w2, w3} = k;
        exp_keys[0] = k;
        rc = 8'h01;
        for (int i = 1; i <= 10; i++) begin
            t  = {tb_sbox(w3[23:16]) ^ rc, tb_sbox(w3[15:8]), tb_sbox(w3[7:0]), tb_sbox(w3[31:24])};
            w0 = w0 ^ t;
            w1 = w1 ^ w0;
            w2 = w2 ^ w1;
            w3 = w3 ^ w2;
            exp_keys[i]     = {w0, w1, w2, w3};
            exp_rcon[10-i]  = rc;
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
        end
    endtask

    // Full walk with out_ready high; optional busy start pulse and held start.
    task automatic walk(input string tag, input int busy_r, input bit hold);
        int h0, d0, lb;
        h0 = hs_count;
        d0 = done_count;
        lb = rcon_log.size();
        key_in    = exp_keys[10];
        start     = 1'b1;
        out_ready = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        for (int r = 10; r >= 0; r--) begin
            chk1($sformatf("%s_valid_r%0d", tag, r), out_valid, 1'b1);
            chk4($sformatf("%s_round_r%0d", tag, r), out_round, 4'(r));
            chk128($sformatf("%s_key_r%0d", tag, r), out_key, exp_keys[r]);
            chk1($sformatf("%s_in_ready_r%0d", tag, r), in_ready, 1'b0);
            chk1($sformatf("%s_done_r%0d", tag, r), done, 1'b0);
            if (r == busy_r) begin
                start  = 1'b1;
                key_in = ~exp_keys[10];
            end
            tick();
            if (r == busy_r) start = 1'b0;
        end
        chk1({tag, "_done_pulse"}, done, 1'b1);
        chk1({tag, "_valid_end"}, out_valid, 1'b0);
        chk1({tag, "_in_ready_end"}, in_ready, 1'b1);
        if (!hold) begin
            tick();
            chk1({tag, "_done_single"}, done, 1'b0);
            chk1({tag, "_idle_stays"}, out_valid, 1'b0);
            chki({tag, "_handshakes"}, hs_count - h0, 11);
            chki({tag, "_done_count"}, done_count - d0, 1);
            for (int j = 0; j < 10; j++)
                chk8($sformatf("%s_rcon_%0d", tag, j), rcon_log[lb + j], exp_rcon[j]);
        end
    endtask

    initial begin
        logic [127:0] cur_k, kb;
        logic [3:0]   cur_r;
        logic         rdy, alt, fin;
        int           er, stalls, h0, d0;

        reset     = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        key_in    = '0;
        #2 reset  = 1'b0;
        #1;
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_valid", out_valid, 1'b0);
        chk128("rst_key", out_key, 128'h0);
        chk4("rst_round", out_round, 4'd0);
        chk1("rst_done", done, 1'b0);
        chk8("rst_rcon", dut.rcon_q, 8'h36);
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk1("post_rst_in_ready", in_ready, 1'b1);
        chk1("post_rst_valid", out_valid, 1'b0);

        // FIPS-197 A.1 round keys and the reverse Rcon sequence
        exp_keys[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        exp_keys[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        exp_keys[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        exp_keys[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        exp_keys[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        exp_keys[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        exp_keys[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        exp_keys[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        exp_keys[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        exp_keys[9]  = 128'hac7766f319fadc2128d12941575c006e;
        exp_keys[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        exp_rcon = '{8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

        walk("fips", -1, 1'b0);

        // Backpressure: 3-cycle stall at round 7, alternating elsewhere
        key_in    = exp_keys[10];
        start     = 1'b1;
        out_ready = 1'b0;
        h0 = hs_count;
        d0 = done_count;
        tick();
        start  = 1'b0;
        er     = 10;
        stalls = 0;
        alt    = 1'b0;
        fin    = 1'b0;
        for (int c = 0; c < 80 && !fin; c++) begin
            chk1("bp_valid", out_valid, 1'b1);
            chk4("bp_round", out_round, 4'(er));
            chk128("bp_key", out_key, exp_keys[er]);
            cur_k = out_key;
            cur_r = out_round;
            if (er == 7 && stalls < 3) begin
                rdy = 1'b0;
                stalls++;
            end else begin
                rdy = alt;
                alt = ~alt;
            end
            out_ready = rdy;
            tick();
            if (rdy) begin
                if (er == 0) fin = 1'b1;
                else er--;
            end else begin
                chk128("bp_hold_key", out_key, cur_k);
                chk4("bp_hold_round", out_round, cur_r);
                chk1("bp_hold_valid", out_valid, 1'b1);
            end
        end
        chk1("bp_finished", fin, 1'b1);
        chki("bp_stalls_r7", stalls, 3);
        chk1("bp_done", done, 1'b1);
        chk1("bp_valid_end", out_valid, 1'b0);
        out_ready = 1'b0;
        tick();
        chki("bp_handshakes", hs_count - h0, 11);
        chki("bp_done_count", done_count - d0, 1);

        // Start pulse with a different key while busy at round 5
        walk("busy", 5, 1'b0);

        // Back-to-back: start held high across done
        walk("b2b1", -1, 1'b1);
        kb = 128'h00112233445566778899aabbccddeeff;
        key_in = kb;
        tick();
        chk1("b2b2_valid", out_valid, 1'b1);
        chk4("b2b2_round", out_round, 4'd10);
        chk128("b2b2_key", out_key, kb);
        chk1("b2b2_in_ready", in_ready, 1'b0);
        start = 1'b0;
        for (int i = 0; i < 11; i++) tick();
        chk1("b2b2_done", done, 1'b1);
        chk1("b2b2_valid_end", out_valid, 1'b0);
        tick();

        // Reset asserted at round 4
        key_in    = exp_keys[10];
        start     = 1'b1;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20 && out_round != 4'd4; i++) tick();
        chk4("mid_round_before", out_round, 4'd4);
        d0 = done_count;
        reset = 1'b0;
        #1;
        chk1("mid_rst_valid", out_valid, 1'b0);
        chk1("mid_rst_done", done, 1'b0);
        chk1("mid_rst_in_ready", in_ready, 1'b1);
        chk4("mid_rst_round", out_round, 4'd0);
        chk128("mid_rst_key", out_key, 128'h0);
        tick();
        reset = 1'b1;
        tick();
        chk1("mid_rel_in_ready", in_ready, 1'b1);
        chk1("mid_rel_valid", out_valid, 1'b0);
        chki("mid_no_done", done_count - d0, 0);
        key_in = exp_keys[10];
        start  = 1'b1;
        tick();
        start = 1'b0;
        chk1("mid_new_valid", out_valid, 1'b1);
        chk4("mid_new_round", out_round, 4'd10);
        chk128("mid_new_key", out_key, exp_keys[10]);
        for (int i = 0; i < 11; i++) tick();
        chk1("mid_new_done", done, 1'b1);
        tick();

        // Random keys checked against a forward expansion model
        for (int n = 0; n < 100; n++) begin
            fwd_expand({$urandom, $urandom, $urandom, $urandom});
            walk($sformatf("rand%0d", n), -1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
